// File: rtl/pc_int_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_int_pkg
// Brief    : Shared defaults, cause width helper and types for pc_int_unit.
// Revision : 1.0 - initial release
// ============================================================================
package pc_int_pkg;

  localparam int          C_PC_W       = 32;
  localparam int          C_N_INT      = 4;
  localparam logic [31:0] C_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] C_VEC_BASE   = 32'h0000_0008;
  localparam logic [31:0] C_VEC_STRIDE = 32'h0000_0004;

  // Width of a source index; a single source still needs one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int C_CW = cw(C_N_INT);

  typedef logic [C_CW-1:0] cause_t;

  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_ISR = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pc_int_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_int_unit_if
// Brief    : CPU-side bundle of the PC / interrupt unit. The master drives
//            pipeline control and interrupt lines; the slave is the unit.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_int_unit_if
  import pc_int_pkg::*;
#(
  parameter int PC_W  = C_PC_W,
  parameter int N_INT = C_N_INT
);
  localparam int CW = cw(N_INT);

  logic             stall;
  logic [N_INT-1:0] int_req;
  logic             rfe;
  logic [PC_W-1:0]  pc_next;
  logic             mask_we;
  logic [N_INT-1:0] mask_wdata;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  epc;
  logic             in_isr;
  logic             int_ack;
  logic [CW-1:0]    int_cause;

  modport master (
    output stall, int_req, rfe, pc_next, mask_we, mask_wdata,
    input  pc, epc, in_isr, int_ack, int_cause
  );

  modport slave (
    input  stall, int_req, rfe, pc_next, mask_we, mask_wdata,
    output pc, epc, in_isr, int_ack, int_cause
  );

endinterface
`default_nettype wire

// File: rtl/pc_int_unit_irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : irq_prio_enc
// Brief    : Fixed-priority encoder, lowest set index wins. Purely
//            combinational.
// Revision : 1.0 - initial release
// ============================================================================
module irq_prio_enc #(
  parameter int N  = 4,
  parameter int CW = 2
) (
  input  logic [N-1:0]  i_vec,
  output logic          o_any,
  output logic [CW-1:0] o_idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = CW'(i);
      end
    end
  end

  assign o_any = |i_vec;

endmodule
`default_nettype wire

// File: rtl/pc_int_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_int_unit
// Brief    : Program-counter register with vectored interrupt entry, EPC save
//            and RFE return. Rising edges on int_req latch into pending;
//            the lowest eligible source redirects fetch to its vector.
//            Build option IRQ_MASK_EN adds a writable source mask; without it
//            every source is always enabled and the mask write port is unused.
// Revision : 1.0 - initial release
// ============================================================================
module pc_int_unit
  import pc_int_pkg::*;
#(
  parameter int              PC_W       = C_PC_W,
  parameter int              N_INT      = C_N_INT,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(C_RESET_PC),
  parameter logic [PC_W-1:0] VEC_BASE   = PC_W'(C_VEC_BASE),
  parameter logic [PC_W-1:0] VEC_STRIDE = PC_W'(C_VEC_STRIDE)
) (
  input logic          clk,
  input logic          reset,
  pc_int_unit_if.slave bus
);

  localparam int CW = cw(N_INT);

  state_t           r_state, w_state_nxt;
  logic [PC_W-1:0]  r_pc, w_pc_nxt;
  logic [PC_W-1:0]  r_epc, w_epc_nxt;
  logic             r_ack, w_ack_nxt;
  logic [CW-1:0]    r_cause, w_cause_nxt;
  logic [N_INT-1:0] r_req_q;
  logic [N_INT-1:0] r_pending, w_pending_nxt;
  logic [N_INT-1:0] w_edge, w_mask, w_elig, w_clr;
  logic [CW-1:0]    w_enc_idx;
  logic             w_enc_any;
  logic             w_in_isr;
  logic             w_take;
  logic [PC_W-1:0]  w_vec_addr;

`ifdef IRQ_MASK_EN
  logic [N_INT-1:0] r_mask;

  // Source mask register; a write takes effect from the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= '1;
    end else if (bus.mask_we) begin
      r_mask <= bus.mask_wdata;
    end
  end

  assign w_mask = r_mask;
`else
  logic w_unused_mask;

  assign w_mask        = '1;
  assign w_unused_mask = ^{bus.mask_we, bus.mask_wdata};
`endif

  assign w_edge   = bus.int_req & ~r_req_q;
  assign w_elig   = r_pending & w_mask;
  assign w_in_isr = (r_state == ST_ISR);

  irq_prio_enc #(
    .N  (N_INT),
    .CW (CW)
  ) u_prio_enc (
    .i_vec (w_elig),
    .o_any (w_enc_any),
    .o_idx (w_enc_idx)
  );

  // An RFE cycle never takes, so one non-ISR instruction always issues first.
  assign w_take     = !bus.stall && !w_in_isr && !bus.rfe && w_enc_any;
  assign w_vec_addr = VEC_BASE + PC_W'(w_enc_idx) * VEC_STRIDE;

  // Next-state and pending update; a fresh edge wins over the take clear.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_epc_nxt   = r_epc;
    w_ack_nxt   = 1'b0;
    w_cause_nxt = r_cause;
    w_clr       = '0;
    if (!bus.stall) begin
      if (bus.rfe && w_in_isr) begin
        w_pc_nxt    = r_epc;
        w_state_nxt = ST_RUN;
      end else if (w_take) begin
        w_epc_nxt          = bus.pc_next;
        w_pc_nxt           = w_vec_addr;
        w_state_nxt        = ST_ISR;
        w_ack_nxt          = 1'b1;
        w_cause_nxt        = w_enc_idx;
        w_clr[w_enc_idx]   = 1'b1;
      end else begin
        w_pc_nxt = bus.pc_next;
      end
    end
    w_pending_nxt = (r_pending & ~w_clr) | w_edge;
  end

  // State registers; edge detection and pending capture run through stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_PC;
      r_epc     <= '0;
      r_ack     <= 1'b0;
      r_cause   <= '0;
      r_req_q   <= '0;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_epc     <= w_epc_nxt;
      r_ack     <= w_ack_nxt;
      r_cause   <= w_cause_nxt;
      r_req_q   <= bus.int_req;
      r_pending <= w_pending_nxt;
    end
  end

  assign bus.pc        = r_pc;
  assign bus.epc       = r_epc;
  assign bus.in_isr    = w_in_isr;
  assign bus.int_ack   = r_ack;
  assign bus.int_cause = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_pc_int_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_int_unit
// Brief    : Self-checking bench for pc_int_unit: per-scenario stimulus tables
//            with expected outputs queued at drive time and compared after
//            each clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_int_unit;
  import pc_int_pkg::*;

  typedef struct {
    logic        stall;
    logic [3:0]  req;
    logic        rfe;
    logic [31:0] pn;
    logic        mwe;
    logic [3:0]  mwd;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        isr;
    logic        ack;
    cause_t      cause;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  pc_int_unit_if bus ();

  pc_int_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t S(input logic st, input logic [3:0] rq, input logic rf,
                              input logic [31:0] pn, input logic mwe = 1'b0,
                              input logic [3:0] mwd = 4'h0);
    stim_t s;
    s.stall = st; s.req = rq; s.rfe = rf; s.pn = pn; s.mwe = mwe; s.mwd = mwd;
    return s;
  endfunction

  function automatic exp_t E(input logic [31:0] pc, input logic [31:0] epc,
                             input logic isr, input logic ack, input cause_t cause);
    exp_t e;
    e.pc = pc; e.epc = epc; e.isr = isr; e.ack = ack; e.cause = cause;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    bus.stall      = s.stall;
    bus.int_req    = s.req;
    bus.rfe        = s.rfe;
    bus.pc_next    = s.pn;
    bus.mask_we    = s.mwe;
    bus.mask_wdata = s.mwd;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.pc !== 32'h0 || bus.epc !== 32'h0 || bus.in_isr !== 1'b0 ||
        bus.int_ack !== 1'b0 || bus.int_cause !== 2'd0) begin
      failures++;
      $display("FAIL reset: got pc=%h epc=%h isr=%b ack=%b cause=%0d, want all zero",
               bus.pc, bus.epc, bus.in_isr, bus.int_ack, bus.int_cause);
    end
  endtask

  task automatic test_sequential();
    exp_t e;
    for (int i = 1; i <= 4; i++) begin
      drive(S(1'b0, 4'h0, 1'b0, 32'(4 * i)));
      exp_q.push_back(E(32'(4 * i), 32'h0, 1'b0, 1'b0, 2'd0));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (bus.pc !== e.pc || bus.epc !== e.epc || bus.in_isr !== e.isr ||
          bus.int_ack !== e.ack || bus.int_cause !== e.cause) begin
        failures++;
        $display("FAIL sequential[%0d]: got pc=%h epc=%h isr=%b ack=%b cause=%0d, want pc=%h epc=%h isr=%b ack=%b cause=%0d",
                 i, bus.pc, bus.epc, bus.in_isr, bus.int_ack, bus.int_cause,
                 e.pc, e.epc, e.isr, e.ack, e.cause);
      end
    end
  endtask

  // Table-driven scenario runner body shared by the name/table pairs below.
  task automatic test_table(input string name, input stim_t st[$], input exp_t ex[$]);
    exp_t e;
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (bus.pc !== e.pc || bus.epc !== e.epc || bus.in_isr !== e.isr ||
          bus.int_ack !== e.ack || bus.int_cause !== e.cause) begin
        failures++;
        $display("FAIL %s[%0d]: got pc=%h epc=%h isr=%b ack=%b cause=%0d, want pc=%h epc=%h isr=%b ack=%b cause=%0d",
                 name, i, bus.pc, bus.epc, bus.in_isr, bus.int_ack, bus.int_cause,
                 e.pc, e.epc, e.isr, e.ack, e.cause);
      end
    end
  endtask

  task automatic test_vector_and_rfe();
    stim_t st[$];
    exp_t  ex[$];
    st.push_back(S(0, 4'b0100, 0, 32'h14)); ex.push_back(E(32'h14, 32'h00, 0, 0, 2'd0));
    st.push_back(S(0, 4'b0100, 0, 32'h40)); ex.push_back(E(32'h10, 32'h40, 1, 1, 2'd2));
    st.push_back(S(0, 4'b0101, 0, 32'h14)); ex.push_back(E(32'h14, 32'h40, 1, 0, 2'd2));
    st.push_back(S(0, 4'b0101, 1, 32'h18)); ex.push_back(E(32'h40, 32'h40, 0, 0, 2'd2));
    st.push_back(S(0, 4'b0101, 0, 32'h44)); ex.push_back(E(32'h08, 32'h44, 1, 1, 2'd0));
    st.push_back(S(0, 4'b0000, 0, 32'h0C)); ex.push_back(E(32'h0C, 32'h44, 1, 0, 2'd0));
    st.push_back(S(0, 4'b0000, 1, 32'h10)); ex.push_back(E(32'h44, 32'h44, 0, 0, 2'd0));
    st.push_back(S(0, 4'b0000, 0, 32'h48)); ex.push_back(E(32'h48, 32'h44, 0, 0, 2'd0));
    test_table("vector_rfe", st, ex);
  endtask

  task automatic test_priority();
    stim_t st[$];
    exp_t  ex[$];
    st.push_back(S(0, 4'b1010, 0, 32'h4C)); ex.push_back(E(32'h4C, 32'h44, 0, 0, 2'd0));
    st.push_back(S(0, 4'b1010, 0, 32'h50)); ex.push_back(E(32'h0C, 32'h50, 1, 1, 2'd1));
    st.push_back(S(0, 4'b1010, 0, 32'h10)); ex.push_back(E(32'h10, 32'h50, 1, 0, 2'd1));
    st.push_back(S(0, 4'b1010, 1, 32'h14)); ex.push_back(E(32'h50, 32'h50, 0, 0, 2'd1));
    st.push_back(S(0, 4'b1010, 0, 32'h54)); ex.push_back(E(32'h14, 32'h54, 1, 1, 2'd3));
    st.push_back(S(0, 4'b0000, 1, 32'h18)); ex.push_back(E(32'h54, 32'h54, 0, 0, 2'd3));
    st.push_back(S(0, 4'b0000, 0, 32'h58)); ex.push_back(E(32'h58, 32'h54, 0, 0, 2'd3));
    test_table("priority", st, ex);
  endtask

  task automatic test_stall();
    stim_t st[$];
    exp_t  ex[$];
    st.push_back(S(1, 4'b0001, 0, 32'h99)); ex.push_back(E(32'h58, 32'h54, 0, 0, 2'd3));
    st.push_back(S(1, 4'b0001, 0, 32'h99)); ex.push_back(E(32'h58, 32'h54, 0, 0, 2'd3));
    st.push_back(S(1, 4'b0001, 0, 32'h99)); ex.push_back(E(32'h58, 32'h54, 0, 0, 2'd3));
    st.push_back(S(0, 4'b0001, 0, 32'h5C)); ex.push_back(E(32'h08, 32'h5C, 1, 1, 2'd0));
    st.push_back(S(1, 4'b0001, 0, 32'h0C)); ex.push_back(E(32'h08, 32'h5C, 1, 0, 2'd0));
    st.push_back(S(0, 4'b0001, 0, 32'h0C)); ex.push_back(E(32'h0C, 32'h5C, 1, 0, 2'd0));
    st.push_back(S(0, 4'b0001, 1, 32'h10)); ex.push_back(E(32'h5C, 32'h5C, 0, 0, 2'd0));
    st.push_back(S(0, 4'b0001, 0, 32'h60)); ex.push_back(E(32'h60, 32'h5C, 0, 0, 2'd0));
    // RFE outside an ISR is ignored and simply advances.
    st.push_back(S(0, 4'b0000, 1, 32'h64)); ex.push_back(E(32'h64, 32'h5C, 0, 0, 2'd0));
    test_table("stall", st, ex);
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    exp_t  ex[$];
    // A new edge in the take cycle re-arms the same source.
    st.push_back(S(1, 4'b0001, 0, 32'h68)); ex.push_back(E(32'h64, 32'h5C, 0, 0, 2'd0));
    st.push_back(S(1, 4'b0000, 0, 32'h68)); ex.push_back(E(32'h64, 32'h5C, 0, 0, 2'd0));
    st.push_back(S(0, 4'b0001, 0, 32'h68)); ex.push_back(E(32'h08, 32'h68, 1, 1, 2'd0));
    st.push_back(S(0, 4'b0001, 1, 32'h0C)); ex.push_back(E(32'h68, 32'h68, 0, 0, 2'd0));
    st.push_back(S(0, 4'b0001, 0, 32'h6C)); ex.push_back(E(32'h08, 32'h6C, 1, 1, 2'd0));
    st.push_back(S(0, 4'b0000, 1, 32'h0C)); ex.push_back(E(32'h6C, 32'h6C, 0, 0, 2'd0));
    test_table("back_to_back", st, ex);
  endtask

  task automatic test_mask();
    stim_t st[$];
    exp_t  ex[$];
`ifdef IRQ_MASK_EN
    st.push_back(S(0, 4'b0000, 0, 32'h70, 1, 4'b1110)); ex.push_back(E(32'h70, 32'h6C, 0, 0, 2'd0));
    st.push_back(S(0, 4'b0001, 0, 32'h74));             ex.push_back(E(32'h74, 32'h6C, 0, 0, 2'd0));
    st.push_back(S(0, 4'b0001, 0, 32'h78));             ex.push_back(E(32'h78, 32'h6C, 0, 0, 2'd0));
    st.push_back(S(0, 4'b0001, 0, 32'h7C, 1, 4'b1111)); ex.push_back(E(32'h7C, 32'h6C, 0, 0, 2'd0));
    st.push_back(S(0, 4'b0001, 0, 32'h80));             ex.push_back(E(32'h08, 32'h80, 1, 1, 2'd0));
`else
    st.push_back(S(0, 4'b0000, 0, 32'h70, 1, 4'b1110)); ex.push_back(E(32'h70, 32'h6C, 0, 0, 2'd0));
    st.push_back(S(0, 4'b0001, 0, 32'h74));             ex.push_back(E(32'h74, 32'h6C, 0, 0, 2'd0));
    st.push_back(S(0, 4'b0001, 0, 32'h78));             ex.push_back(E(32'h08, 32'h78, 1, 1, 2'd0));
`endif
    test_table("mask", st, ex);
  endtask

  task automatic test_reset_mid_isr();
    stim_t st[$];
    exp_t  ex[$];
    st.push_back(S(0, 4'b0011, 0, 32'h0C)); ex.push_back(E(32'h0C, 32'h00, 1, 0, 2'd0));
    // epc of the entry above depends on the mask build; compare pc/isr only there.
    drive(st[0]);
    @(posedge clk); #1;
    checks++;
    if (bus.pc !== ex[0].pc || bus.in_isr !== ex[0].isr) begin
      failures++;
      $display("FAIL reset_mid_isr_pre: got pc=%h isr=%b, want pc=%h isr=%b",
               bus.pc, bus.in_isr, ex[0].pc, ex[0].isr);
    end
    drive(S(0, 4'b0000, 0, 32'h04));
    reset = 1'b1;
    #1;
    checks++;
    if (bus.pc !== 32'h0 || bus.epc !== 32'h0 || bus.in_isr !== 1'b0 ||
        bus.int_ack !== 1'b0 || bus.int_cause !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid_isr: got pc=%h epc=%h isr=%b ack=%b cause=%0d, want all zero",
               bus.pc, bus.epc, bus.in_isr, bus.int_ack, bus.int_cause);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    st.delete();
    ex.delete();
    // Pending source 1 was discarded by reset: no take afterwards.
    st.push_back(S(0, 4'b0000, 0, 32'h04)); ex.push_back(E(32'h04, 32'h00, 0, 0, 2'd0));
    st.push_back(S(0, 4'b0000, 0, 32'h08)); ex.push_back(E(32'h08, 32'h00, 0, 0, 2'd0));
    st.push_back(S(0, 4'b0000, 0, 32'h0C)); ex.push_back(E(32'h0C, 32'h00, 0, 0, 2'd0));
    test_table("after_reset", st, ex);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(S(0, 4'h0, 0, 32'h0));
    @(posedge clk);
    @(posedge clk); #1;
    test_reset();
    reset = 1'b0;
    test_sequential();
    test_vector_and_rfe();
    test_priority();
    test_stall();
    test_back_to_back();
    test_mask();
    test_reset_mid_isr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
